// File: rtl/pzbcm_sram_pkg.sv
// Shared types for the 1RW SRAM controller.
package pzbcm_sram_pkg;

  // Winner of a read/write conflict; also used as the round-robin priority
  // holder (the side that wins the next conflict).
  typedef enum logic {
    GRANT_READ  = 1'b0,
    GRANT_WRITE = 1'b1
  } pzbcm_sram_grant_t;

endpackage

// File: rtl/pzbcm_fifo.sv
// Small synchronous FIFO with occupancy count; output shows the head entry.
module pzbcm_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 3
)(
  input  logic                         i_clk,
  input  logic                         i_rst_n,
  input  logic                         i_push,
  input  logic [WIDTH-1:0]             i_data,
  input  logic                         i_pop,
  output logic [WIDTH-1:0]             o_data,
  output logic                         o_empty,
  output logic [$clog2(DEPTH+1)-1:0]   o_count
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DEPTH-1:0][WIDTH-1:0] mem_q, mem_d;
  logic [PTR_W-1:0]            wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CNT_W-1:0]            cnt_q, cnt_d;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Next-state for storage, pointers and occupancy.
  always_comb begin
    mem_d  = mem_q;
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (i_push) begin
      mem_d[wptr_q] = i_data;
      wptr_d        = ptr_inc(wptr_q);
    end
    if (i_pop) rptr_d = ptr_inc(rptr_q);
    case ({i_push, i_pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  // State registers; storage is cleared so the head reads zero after reset.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      mem_q  <= '0;
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      mem_q  <= mem_d;
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

  assign o_data  = mem_q[rptr_q];
  assign o_empty = (cnt_q == '0);
  assign o_count = cnt_q;

endmodule

// File: rtl/pzbcm_sram_1rw_controller.sv
// Arbitrates read/write requests onto a single-port SRAM and buffers read
// responses behind a credit scheme so no read is ever dropped.
module pzbcm_sram_1rw_controller
  import pzbcm_sram_pkg::*;
#(
  parameter int ADDRESS_WIDTH  = 8,
  parameter int DATA_WIDTH     = 32,
  parameter int READ_LATENCY   = 1,
  parameter int RESPONSE_DEPTH = READ_LATENCY + 2
)(
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_write_valid,
  output logic                     o_write_ready,
  input  logic [ADDRESS_WIDTH-1:0] i_write_address,
  input  logic [DATA_WIDTH-1:0]    i_write_data,
  input  logic                     i_read_valid,
  output logic                     o_read_ready,
  input  logic [ADDRESS_WIDTH-1:0] i_read_address,
  output logic                     o_read_response_valid,
  input  logic                     i_read_response_ready,
  output logic [DATA_WIDTH-1:0]    o_read_data,
  output logic                     o_sram_enable,
  output logic                     o_sram_write,
  output logic [ADDRESS_WIDTH-1:0] o_sram_pointer,
  output logic [DATA_WIDTH-1:0]    o_sram_write_data,
  input  logic [DATA_WIDTH-1:0]    i_sram_read_data
);

  localparam int CNT_W = $clog2(RESPONSE_DEPTH + 1);

  pzbcm_sram_grant_t         prio_q, prio_d;
  logic [READ_LATENCY:0]     vld_pipe_q, vld_pipe_d;
  logic                      sram_enable_q, sram_enable_d;
  logic                      sram_write_q, sram_write_d;
  logic [ADDRESS_WIDTH-1:0]  sram_pointer_q, sram_pointer_d;
  logic [DATA_WIDTH-1:0]     sram_write_data_q, sram_write_data_d;
  logic [CNT_W-1:0]          rsp_count;
  logic                      rsp_empty, rsp_push, rsp_pop;
  logic                      read_eligible, read_req, write_accept, read_accept;
  int                        credit_used;

  // A popping response frees its slot this same cycle.
  always_comb begin
    credit_used   = $countones(vld_pipe_q) + int'(rsp_count) - int'(rsp_pop);
    read_eligible = (credit_used < RESPONSE_DEPTH);
  end

  assign read_req = i_read_valid && read_eligible;

  // Round-robin arbitration; each ready looks only at the other side's request.
  always_comb begin
    prio_d        = prio_q;
    o_write_ready = i_rst_n && (!read_req || (prio_q == GRANT_WRITE));
    o_read_ready  = i_rst_n && read_eligible &&
                    (!i_write_valid || (prio_q == GRANT_READ));
    if (i_write_valid && read_req)
      prio_d = (prio_q == GRANT_READ) ? GRANT_WRITE : GRANT_READ;
  end

  assign write_accept = i_write_valid && o_write_ready;
  assign read_accept  = i_read_valid  && o_read_ready;

  // SRAM command for the accepted request; address/data hold when idle.
  always_comb begin
    sram_enable_d     = write_accept || read_accept;
    sram_write_d      = sram_write_q;
    sram_pointer_d    = sram_pointer_q;
    sram_write_data_d = sram_write_data_q;
    if (write_accept) begin
      sram_write_d      = 1'b1;
      sram_pointer_d    = i_write_address;
      sram_write_data_d = i_write_data;
    end else if (read_accept) begin
      sram_write_d      = 1'b0;
      sram_pointer_d    = i_read_address;
    end
  end

  // In-flight read tracker: the last stage marks the cycle SRAM data is valid.
  always_comb begin
    vld_pipe_d[0] = read_accept;
    for (int i = 1; i <= READ_LATENCY; i++) vld_pipe_d[i] = vld_pipe_q[i-1];
  end

  // Registers; reset drops in-flight reads so late SRAM data is never pushed.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      prio_q            <= GRANT_READ;
      vld_pipe_q        <= '0;
      sram_enable_q     <= 1'b0;
      sram_write_q      <= 1'b0;
      sram_pointer_q    <= '0;
      sram_write_data_q <= '0;
    end else begin
      prio_q            <= prio_d;
      vld_pipe_q        <= vld_pipe_d;
      sram_enable_q     <= sram_enable_d;
      sram_write_q      <= sram_write_d;
      sram_pointer_q    <= sram_pointer_d;
      sram_write_data_q <= sram_write_data_d;
    end
  end

  assign o_sram_enable     = sram_enable_q;
  assign o_sram_write      = sram_write_q;
  assign o_sram_pointer    = sram_pointer_q;
  assign o_sram_write_data = sram_write_data_q;

  assign rsp_push              = vld_pipe_q[READ_LATENCY];
  assign rsp_pop               = o_read_response_valid && i_read_response_ready;
  assign o_read_response_valid = !rsp_empty;

  pzbcm_fifo #(
    .WIDTH (DATA_WIDTH),
    .DEPTH (RESPONSE_DEPTH)
  ) u_response_fifo (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_push  (rsp_push),
    .i_data  (i_sram_read_data),
    .i_pop   (rsp_pop),
    .o_data  (o_read_data),
    .o_empty (rsp_empty),
    .o_count (rsp_count)
  );

endmodule

// File: tb/tb_pzbcm_sram_1rw_controller.sv
// Bench: directed sequences and a vector table on a READ_LATENCY=1 instance,
// random traffic on a READ_LATENCY=3 instance, both scored against a memory model.
module tb_pzbcm_sram_1rw_controller;
  localparam int AW = 8;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] init_val(input int a);
    return 32'hC0DE_0000 | 32'(a);
  endfunction

  // ---------------- instance A (READ_LATENCY=1) ----------------
  logic a_wv, a_wrdy, a_rv, a_rrdy, a_sv, a_srdy, a_sen, a_swr;
  logic [AW-1:0] a_waddr, a_raddr, a_sptr;
  logic [DW-1:0] a_wdata, a_rdata, a_swd;
  logic [DW-1:0] a_srd = '0;

  pzbcm_sram_1rw_controller #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .READ_LATENCY(1)) u_dut_a (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_write_valid(a_wv), .o_write_ready(a_wrdy), .i_write_address(a_waddr), .i_write_data(a_wdata),
    .i_read_valid(a_rv), .o_read_ready(a_rrdy), .i_read_address(a_raddr),
    .o_read_response_valid(a_sv), .i_read_response_ready(a_srdy), .o_read_data(a_rdata),
    .o_sram_enable(a_sen), .o_sram_write(a_swr), .o_sram_pointer(a_sptr),
    .o_sram_write_data(a_swd), .i_sram_read_data(a_srd));

  logic [DW-1:0] mem_a [int];
  always @(posedge clk) begin
    if (a_sen) begin
      if (a_swr) mem_a[int'(a_sptr)] = a_swd;
      else a_srd <= mem_a.exists(int'(a_sptr)) ? mem_a[int'(a_sptr)] : init_val(int'(a_sptr));
    end
  end

  logic [DW-1:0] ma [int];
  logic [DW-1:0] qa [$];
  int a_pops = 0;
  always @(negedge clk) begin
    if (!rst_n) qa.delete();
    else begin
      if (a_sv && a_srdy) begin
        a_pops++;
        if (qa.size() == 0) begin
          checks++; failures++;
          $display("FAIL a_rsp_unexpected: got %0h expected none", a_rdata);
        end else chk("a_rsp", a_rdata, qa.pop_front());
      end
      if (a_wv && a_wrdy) ma[int'(a_waddr)] = a_wdata;
      if (a_rv && a_rrdy)
        qa.push_back(ma.exists(int'(a_raddr)) ? ma[int'(a_raddr)] : init_val(int'(a_raddr)));
    end
  end

  // ---------------- instance B (READ_LATENCY=3) ----------------
  logic b_wv, b_wrdy, b_rv, b_rrdy, b_sv, b_srdy, b_sen, b_swr;
  logic [AW-1:0] b_waddr, b_raddr, b_sptr;
  logic [DW-1:0] b_wdata, b_rdata, b_swd;
  logic [DW-1:0] b_p0 = '0, b_p1 = '0, b_srd = '0;

  pzbcm_sram_1rw_controller #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .READ_LATENCY(3)) u_dut_b (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_write_valid(b_wv), .o_write_ready(b_wrdy), .i_write_address(b_waddr), .i_write_data(b_wdata),
    .i_read_valid(b_rv), .o_read_ready(b_rrdy), .i_read_address(b_raddr),
    .o_read_response_valid(b_sv), .i_read_response_ready(b_srdy), .o_read_data(b_rdata),
    .o_sram_enable(b_sen), .o_sram_write(b_swr), .o_sram_pointer(b_sptr),
    .o_sram_write_data(b_swd), .i_sram_read_data(b_srd));

  logic [DW-1:0] mem_b [int];
  always @(posedge clk) begin
    if (b_sen) begin
      if (b_swr) mem_b[int'(b_sptr)] = b_swd;
      else b_p0 <= mem_b.exists(int'(b_sptr)) ? mem_b[int'(b_sptr)] : init_val(int'(b_sptr));
    end
    b_p1  <= b_p0;
    b_srd <= b_p1;
  end

  logic [DW-1:0] mb [int];
  logic [DW-1:0] qb [$];
  int b_pops = 0;
  int b_pushes = 0;
  always @(negedge clk) begin
    if (!rst_n) qb.delete();
    else begin
      if (b_sv && b_srdy) begin
        b_pops++;
        if (qb.size() == 0) begin
          checks++; failures++;
          $display("FAIL b_rsp_unexpected: got %0h expected none", b_rdata);
        end else chk("b_rsp", b_rdata, qb.pop_front());
      end
      if (b_wv && b_wrdy) mb[int'(b_waddr)] = b_wdata;
      if (b_rv && b_rrdy) begin
        b_pushes++;
        qb.push_back(mb.exists(int'(b_raddr)) ? mb[int'(b_raddr)] : init_val(int'(b_raddr)));
      end
    end
  end

  // ---------------- vector table ----------------
  typedef struct {
    logic          wv;
    logic          rv;
    logic [AW-1:0] waddr;
    logic [AW-1:0] raddr;
    logic [DW-1:0] wdata;
    logic          exp_w;   // expected o_write_ready
    logic          exp_r;   // expected o_read_ready
  } vec_t;
  vec_t tbl [10];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sram_chk(input vec_t v, input int i);
    logic wa, ra;
    wa = v.wv & v.exp_w;
    ra = v.rv & v.exp_r;
    chk($sformatf("tbl%0d_sram_en", i), a_sen, wa | ra);
    if (wa | ra) begin
      chk($sformatf("tbl%0d_sram_wr", i), a_swr, wa);
      chk($sformatf("tbl%0d_sram_ptr", i), a_sptr, wa ? v.waddr : v.raddr);
      if (wa) chk($sformatf("tbl%0d_sram_wd", i), a_swd, v.wdata);
    end
  endtask

  int racc, wacc, pops0, nacc, cyc;

  initial begin
    #1000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    tbl[0] = '{1'b1, 1'b1, 8'h40, 8'h41, 32'h1111_1111, 1'b0, 1'b1};
    tbl[1] = '{1'b1, 1'b1, 8'h20, 8'h42, 32'h2222_2222, 1'b1, 1'b0};
    tbl[2] = '{1'b1, 1'b1, 8'h43, 8'h20, 32'h3333_3333, 1'b0, 1'b1};
    tbl[3] = '{1'b1, 1'b1, 8'h44, 8'h45, 32'h4444_4444, 1'b1, 1'b0};
    tbl[4] = '{1'b1, 1'b1, 8'h46, 8'h44, 32'h5555_5555, 1'b0, 1'b1};
    tbl[5] = '{1'b1, 1'b1, 8'h47, 8'h48, 32'h6666_6666, 1'b1, 1'b0};
    tbl[6] = '{1'b1, 1'b0, 8'h49, 8'h00, 32'h7777_7777, 1'b1, 1'b1};
    tbl[7] = '{1'b0, 1'b1, 8'h00, 8'h49, 32'h0000_0000, 1'b0, 1'b1};
    tbl[8] = '{1'b0, 1'b0, 8'h00, 8'h00, 32'h0000_0000, 1'b1, 1'b1};
    tbl[9] = '{1'b1, 1'b1, 8'h4A, 8'h47, 32'h8888_8888, 1'b0, 1'b1};

    a_waddr = '0; a_raddr = '0; a_wdata = '0; a_srdy = 1'b1;
    b_waddr = '0; b_raddr = '0; b_wdata = '0; b_srdy = 1'b1;
    a_wv = 1'b1; a_rv = 1'b1; b_wv = 1'b1; b_rv = 1'b1;

    // Reset state, readies held low despite valid requests
    #2;
    chk("rst_a_wready", a_wrdy, 0);
    chk("rst_a_rready", a_rrdy, 0);
    chk("rst_b_wready", b_wrdy, 0);
    chk("rst_b_rready", b_rrdy, 0);
    chk("rst_sen", a_sen, 0);
    chk("rst_swr", a_swr, 0);
    chk("rst_sptr", a_sptr, 0);
    chk("rst_swd", a_swd, 0);
    chk("rst_rsp_valid", a_sv, 0);
    chk("rst_rdata", a_rdata, 0);
    repeat (2) @(posedge clk);
    #1;
    a_wv = 0; a_rv = 0; b_wv = 0; b_rv = 0;
    rst_n = 1'b1;

    // Write 0x10 then read it back
    tick(); a_wv = 1; a_waddr = 8'h10; a_wdata = 32'hDEAD_BEEF;
    @(negedge clk); chk("t1_wready", a_wrdy, 1);
    tick(); a_wv = 0; a_rv = 1; a_raddr = 8'h10;
    @(negedge clk);
    chk("t1_rready", a_rrdy, 1);
    chk("t1_sen_write", a_sen, 1);
    chk("t1_swr", a_swr, 1);
    chk("t1_sptr_w", a_sptr, 8'h10);
    chk("t1_swd", a_swd, 32'hDEAD_BEEF);
    tick(); a_rv = 0;
    @(negedge clk);
    chk("t1_sen_read", a_sen, 1);
    chk("t1_swr_read", a_swr, 0);
    chk("t1_sptr_r", a_sptr, 8'h10);
    chk("t1_no_rsp_early", a_sv, 0);
    tick();
    @(negedge clk);
    chk("t1_sen_idle", a_sen, 0);
    chk("t1_no_rsp_t2", a_sv, 0);
    tick();
    @(negedge clk);
    chk("t1_rsp_valid", a_sv, 1);
    chk("t1_rsp_data", a_rdata, 32'hDEAD_BEEF);

    // Vector table: round-robin conflicts, single requesters, idle
    for (int i = 0; i < 10; i++) begin
      tick();
      a_wv = tbl[i].wv; a_rv = tbl[i].rv;
      a_waddr = tbl[i].waddr; a_raddr = tbl[i].raddr; a_wdata = tbl[i].wdata;
      @(negedge clk);
      chk($sformatf("tbl%0d_wready", i), a_wrdy, tbl[i].exp_w);
      chk($sformatf("tbl%0d_rready", i), a_rrdy, tbl[i].exp_r);
      if (i > 0) sram_chk(tbl[i-1], i - 1);
    end
    tick(); a_wv = 0; a_rv = 0;
    @(negedge clk); sram_chk(tbl[9], 9);
    repeat (4) tick();

    // Response stall: credits limit reads to 3, writes keep flowing
    racc = 0; wacc = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      a_srdy = 0; a_rv = 1; a_raddr = AW'(32'h20 + i);
      a_wv = (i >= 8); a_waddr = AW'(32'h30 + i); a_wdata = 32'hC0FF_EE00 + 32'(i);
      @(negedge clk);
      if (a_rv && a_rrdy) racc++;
      if (a_wv && a_wrdy) wacc++;
    end
    chk("t3_read_accepts", racc, 3);
    chk("t3_rready_low", a_rrdy, 0);
    chk("t3_write_accepts", wacc, 2);
    tick(); a_rv = 0; a_wv = 0;
    @(negedge clk);
    chk("t3_valid_held", a_sv, 1);
    chk("t3_head_data", a_rdata, 32'h2222_2222);
    tick(); tick();
    @(negedge clk);
    chk("t3_valid_still", a_sv, 1);
    chk("t3_data_stable", a_rdata, 32'h2222_2222);
    pops0 = a_pops;
    tick(); a_srdy = 1; a_rv = 1; a_raddr = 8'h50;
    @(negedge clk); chk("t3_read_on_pop", a_rrdy, 1);
    tick(); a_rv = 0;
    for (int c = 0; c < 20 && (a_pops - pops0) < 4; c++) @(negedge clk);
    @(posedge clk);
    chk("t3_resp_count", a_pops - pops0, 4);
    chk("t3_queue_empty", qa.size(), 0);

    // Reset one cycle after a read is issued
    tick(); a_rv = 1; a_raddr = 8'h60;
    @(negedge clk); chk("t4_read_accepted", a_rrdy, 1);
    tick(); a_rv = 0;
    #1 rst_n = 0;
    a_wv = 1; a_rv = 1;
    #1;
    chk("t4_sen", a_sen, 0);
    chk("t4_swr", a_swr, 0);
    chk("t4_sptr", a_sptr, 0);
    chk("t4_swd", a_swd, 0);
    chk("t4_rsp_valid", a_sv, 0);
    chk("t4_rdata", a_rdata, 0);
    chk("t4_wready", a_wrdy, 0);
    chk("t4_rready", a_rrdy, 0);
    repeat (2) @(posedge clk);
    #1;
    a_wv = 0; a_rv = 0; rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk($sformatf("t4_no_resp%0d", i), a_sv, 0);
    end

    // Random mixed traffic on the READ_LATENCY=3 instance
    nacc = 0; cyc = 0;
    while (nacc < 100 && cyc < 3000) begin
      tick();
      b_wv = 1'($urandom_range(0, 1));
      b_rv = 1'($urandom_range(0, 1));
      b_waddr = AW'($urandom_range(0, 15));
      b_raddr = AW'($urandom_range(0, 15));
      b_wdata = $urandom();
      b_srdy = ($urandom_range(0, 2) != 0);
      @(negedge clk);
      if ((b_wv && b_wrdy) || (b_rv && b_rrdy)) nacc++;
      cyc++;
    end
    chk("t5_accepted", nacc, 100);
    tick(); b_wv = 0; b_rv = 0; b_srdy = 1;
    for (int c = 0; c < 50 && qb.size() != 0; c++) @(negedge clk);
    @(posedge clk);
    chk("t5_drained", qb.size(), 0);
    chk("t5_push_pop", b_pops, b_pushes);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pzbcm_sram_1rw_controller.md
PZBCM_SRAM_1RW_CONTROLLER -- requirements
Module: pzbcm_sram_1rw_controller

Interface
- REQ-001 SHALL have parameter ADDRESS_WIDTH, default 8, meaning the SRAM word address width.
- REQ-002 SHALL have parameter DATA_WIDTH, default 32, meaning the SRAM word width.
- REQ-003 SHALL have parameter READ_LATENCY, default 1, meaning cycles from o_sram_enable with read until i_sram_read_data is valid.
- REQ-004 SHALL have parameter RESPONSE_DEPTH, default READ_LATENCY+2, meaning response buffer entries; minimum 1.
- REQ-005 SHALL have port i_clk, input, 1, the single clock.
- REQ-006 SHALL have port i_rst_n, input, 1, asynchronous active-low reset.
- REQ-007 SHALL have write request ports i_write_valid (in, 1), o_write_ready (out, 1), i_write_address (in, ADDRESS_WIDTH), i_write_data (in, DATA_WIDTH).
- REQ-008 SHALL have read request ports i_read_valid (in, 1), o_read_ready (out, 1), i_read_address (in, ADDRESS_WIDTH).
- REQ-009 SHALL have read response ports o_read_response_valid (out, 1), i_read_response_ready (in, 1), o_read_data (out, DATA_WIDTH).
- REQ-010 SHALL have SRAM-side ports o_sram_enable (out, 1), o_sram_write (out, 1), o_sram_pointer (out, ADDRESS_WIDTH), o_sram_write_data (out, DATA_WIDTH), i_sram_read_data (in, DATA_WIDTH); these connect directly to a 1RW SRAM wrapper.

Function
- REQ-011 SHALL accept a request when valid and ready are both high at a rising i_clk; at most one request (read or write) is accepted per cycle.
- REQ-012 SHALL grant the only valid requester when one of read/write is valid and eligible.
- REQ-013 SHALL, when both are valid and eligible, grant the side not granted on the previous conflict (round-robin); the first conflict after reset goes to read.
- REQ-014 SHALL treat read as eligible only when in-flight reads plus response buffer occupancy < RESPONSE_DEPTH; an ineligible read SHALL NOT block the write.
- REQ-015 SHALL derive o_write_ready/o_read_ready combinationally from grant; ready SHALL NOT depend on its own valid.
- REQ-016 SHALL register SRAM-side outputs: request accepted at cycle T drives o_sram_enable=1, o_sram_write, o_sram_pointer, o_sram_write_data during T+1; o_sram_enable=0 in idle cycles, other SRAM outputs hold last values.
- REQ-017 SHALL capture i_sram_read_data at T+1+READ_LATENCY for a read accepted at T and push it into the response buffer; o_read_response_valid earliest at T+2+READ_LATENCY.
- REQ-018 SHALL return read responses in acceptance order, with no loss or duplication under any i_read_response_ready pattern.
- REQ-019 SHALL hold o_read_data stable while o_read_response_valid=1 and i_read_response_ready=0.
- REQ-020 SHALL sustain one accepted request per cycle when i_read_response_ready is held high and RESPONSE_DEPTH >= READ_LATENCY+2.
- REQ-021 SHALL allow a read to the address written in the previous cycle; it returns the new data (SRAM order preserved).
- REQ-022 SHALL free a credit in the same cycle a response pops, so a read may be accepted in a cycle the buffer is full but popping.

Reset
- REQ-023 SHALL on i_rst_n low asynchronously clear: o_sram_enable=0, o_sram_write=0, o_sram_pointer=0, o_sram_write_data=0, o_read_response_valid=0, o_read_data=0, in-flight count=0, round-robin state=read-first.
- REQ-024 SHALL discard in-flight reads on reset mid-operation; SRAM data returning after reset release SHALL NOT be pushed.
- REQ-025 SHALL hold o_write_ready and o_read_ready low while i_rst_n is low.

Structure
- REQ-026 SHALL place the grant enum (GRANT_READ, GRANT_WRITE) in pzbcm_sram_pkg.
- REQ-027 SHALL implement the response buffer with the existing pzbcm_fifo instance as its one sub-module.
- REQ-028 SHALL track in-flight reads with a READ_LATENCY+1-deep valid shift register.

Verification
- REQ-029 SHALL cover: write addr 0x10 data 0xDEADBEEF then read 0x10 -> o_sram_enable pulses at T+1 each, response 0xDEADBEEF at T_read+3 (READ_LATENCY=1).
- REQ-030 SHALL cover: both valid 6 cycles continuously -> grants alternate R,W,R,W,R,W; all 6 SRAM enables consecutive.
- REQ-031 SHALL cover: i_read_response_ready=0, 10 back-to-back reads -> exactly 3 accepted, o_read_ready low thereafter, writes still accepted; releasing ready returns 3 responses in order.
- REQ-032 SHALL cover: reset asserted one cycle after a read is issued -> no response after release, all outputs at reset values during reset.
- REQ-033 SHALL cover: READ_LATENCY=3, 100 random read/write mixed with random response ready -> scoreboard matches every read, zero drops/duplicates.
